// File: rtl/ctrl_pipe_hazard_if.sv
// ---------------------------------------------------------------------------
// ctrl_pipe_hazard_if
// Decoded control bundle for the instruction currently in ID, as produced by
// the instruction decoder and consumed by ctrl_pipe_hazard.
//   id_alu_op        2  alu_op: 0 add, 1 sub, 2 R-type
//   id_reg_dst ..    1  decoder control bits
//   id_rs/rt/rd      5  register fields of the ID instruction
// Modports: master = decoder (drives), slave = pipeline control (reads).
// ---------------------------------------------------------------------------
interface ctrl_pipe_hazard_if;
  logic [1:0] id_alu_op;
  logic       id_reg_dst;
  logic       id_branch;
  logic       id_mem_read;
  logic       id_mem_2_reg;
  logic       id_mem_write;
  logic       id_alu_src;
  logic       id_reg_write;
  logic       id_jump;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic [4:0] id_rd;

  modport master (
    output id_alu_op, id_reg_dst, id_branch, id_mem_read, id_mem_2_reg,
           id_mem_write, id_alu_src, id_reg_write, id_jump,
           id_rs, id_rt, id_rd
  );

  modport slave (
    input  id_alu_op, id_reg_dst, id_branch, id_mem_read, id_mem_2_reg,
           id_mem_write, id_alu_src, id_reg_write, id_jump,
           id_rs, id_rt, id_rd
  );
endinterface

// File: rtl/ctrl_pipe_hazard.sv
// ---------------------------------------------------------------------------
// ctrl_pipe_hazard
// Carries the decoded control bundle through ID/EX, EX/MEM and MEM/WB,
// resolves the destination register, detects load-use hazards, taken
// branches and jumps, and drives PC / IF-ID stall, flush and redirect.
// Saturating counters record stall cycles and flush cycles.
// Ports:
//   clk, arst_n          clock, async active-low reset
//   dec                  ID control bundle (ctrl_pipe_hazard_if.slave)
//   ex_alu_zero          ALU zero flag of the EX instruction
//   ex_* / mem_* / wb_*  stage control registers and destinations
//   pc_write, if_id_write, if_id_flush, pc_src_branch, pc_src_jump
//                        combinational front-end controls
//   stall_count, flush_count  saturating event counters (CNT_W bits)
// ---------------------------------------------------------------------------
module ctrl_pipe_hazard #(
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  arst_n,
  ctrl_pipe_hazard_if.slave     dec,
  input  logic                  ex_alu_zero,
  output logic [1:0]            ex_alu_op,
  output logic                  ex_alu_src,
  output logic                  ex_branch,
  output logic                  ex_mem_read,
  output logic                  ex_mem_write,
  output logic                  ex_mem_2_reg,
  output logic                  ex_reg_write,
  output logic [4:0]            ex_dest,
  output logic                  mem_mem_read,
  output logic                  mem_mem_write,
  output logic                  mem_mem_2_reg,
  output logic                  mem_reg_write,
  output logic [4:0]            mem_dest,
  output logic                  wb_mem_2_reg,
  output logic                  wb_reg_write,
  output logic [4:0]            wb_dest,
  output logic                  pc_write,
  output logic                  if_id_write,
  output logic                  if_id_flush,
  output logic                  pc_src_branch,
  output logic                  pc_src_jump,
  output logic [CNT_W-1:0]      stall_count,
  output logic [CNT_W-1:0]      flush_count
);

  // ID/EX payload; the jump bit is not carried since the redirect happens in ID.
  typedef struct packed {
    logic [1:0] alu_op;
    logic       alu_src;
    logic       branch;
    logic       mem_read;
    logic       mem_write;
    logic       mem_2_reg;
    logic       reg_write;
    logic [4:0] dest;
  } id_ex_t;

  id_ex_t id_bundle;
  id_ex_t id_ex_q;
  id_ex_t id_ex_d;

  logic uses_rs;
  logic uses_rt;
  logic load_use;
  logic br_take;
  logic stall_active;

  assign id_bundle.alu_op    = dec.id_alu_op;
  assign id_bundle.alu_src   = dec.id_alu_src;
  assign id_bundle.branch    = dec.id_branch;
  assign id_bundle.mem_read  = dec.id_mem_read;
  assign id_bundle.mem_write = dec.id_mem_write;
  assign id_bundle.mem_2_reg = dec.id_mem_2_reg;
  assign id_bundle.reg_write = dec.id_reg_write;
  assign id_bundle.dest      = dec.id_reg_dst ? dec.id_rd : dec.id_rt;

  // Jumps read no register; rt is a source only for R-type, branch and store.
  assign uses_rs = !dec.id_jump;
  assign uses_rt = dec.id_reg_dst | dec.id_branch | dec.id_mem_write;

  // r0 is hard-wired zero, so a load targeting it can never be a hazard.
  assign load_use = ex_mem_read && (ex_dest != 5'd0) &&
                    ((uses_rs && (dec.id_rs == ex_dest)) ||
                     (uses_rt && (dec.id_rt == ex_dest)));

  assign br_take      = ex_branch & ex_alu_zero;
  assign stall_active = load_use & ~br_take;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the priority chain leaves a signal unassigned (no latch).
  always_comb begin
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    if_id_flush   = 1'b0;
    pc_src_branch = 1'b0;
    pc_src_jump   = 1'b0;
    id_ex_d       = id_bundle;
    if (br_take) begin
      // The branch resolves in EX: both younger instructions are wrong-path.
      pc_src_branch = 1'b1;
      if_id_flush   = 1'b1;
      id_ex_d       = '0;
    end else if (load_use) begin
      // Hold PC and IF/ID for one cycle; the bubble clears ex_mem_read.
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_d     = '0;
    end else if (dec.id_jump) begin
      pc_src_jump = 1'b1;
      if_id_flush = 1'b1;
    end
  end

  // NOTE: all pipeline state is cleared by the async reset so that no stale
  // bundle or pending hazard survives it; sequential state uses <= only so
  // every stage samples the pre-edge value of the stage before it.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      id_ex_q       <= '0;
      mem_mem_read  <= 1'b0;
      mem_mem_write <= 1'b0;
      mem_mem_2_reg <= 1'b0;
      mem_reg_write <= 1'b0;
      mem_dest      <= 5'd0;
      wb_mem_2_reg  <= 1'b0;
      wb_reg_write  <= 1'b0;
      wb_dest       <= 5'd0;
    end else begin
      id_ex_q       <= id_ex_d;
      // Later stages never stall: a held ID instruction leaves a bubble behind.
      mem_mem_read  <= id_ex_q.mem_read;
      mem_mem_write <= id_ex_q.mem_write;
      mem_mem_2_reg <= id_ex_q.mem_2_reg;
      mem_reg_write <= id_ex_q.reg_write;
      mem_dest      <= id_ex_q.dest;
      wb_mem_2_reg  <= mem_mem_2_reg;
      wb_reg_write  <= mem_reg_write;
      wb_dest       <= mem_dest;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (stall_active && (stall_count != '1))
        stall_count <= stall_count + CNT_W'(1);
      if (if_id_flush && (flush_count != '1))
        flush_count <= flush_count + CNT_W'(1);
    end
  end

  assign ex_alu_op    = id_ex_q.alu_op;
  assign ex_alu_src   = id_ex_q.alu_src;
  assign ex_branch    = id_ex_q.branch;
  assign ex_mem_read  = id_ex_q.mem_read;
  assign ex_mem_write = id_ex_q.mem_write;
  assign ex_mem_2_reg = id_ex_q.mem_2_reg;
  assign ex_reg_write = id_ex_q.reg_write;
  assign ex_dest      = id_ex_q.dest;

endmodule
